// File: rtl/ysyx_210544_wbu_pkg.sv
// Shared widths, load funct3 codes and the writeback stage-register layout
// for the ysyx_210544 writeback unit.
package ysyx_210544_wbu_pkg;

  localparam int BUS_64   = 64;
  localparam int BUS_RIDX = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic [BUS_64-1:0]   pc;
    logic [31:0]         inst;
    logic [BUS_RIDX-1:0] rd;
    logic                rd_wen;
    logic                wb_sel;
    logic [2:0]          ld_op;
    logic [2:0]          addr_lo;
    logic [BUS_64-1:0]   alu_data;
    logic [BUS_64-1:0]   mem_rdata;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_210544_wbu_ld_ext.sv
// Load data extraction: aligns the addressed bytes of a raw doubleword to
// bit 0 and sign/zero-extends according to the load funct3.
module ysyx_210544_ld_ext
  import ysyx_210544_wbu_pkg::*;
(
  input  logic [2:0]        i_ld_op,
  input  logic [2:0]        i_addr_lo,
  input  logic [BUS_64-1:0] i_rdata,
  output logic [BUS_64-1:0] o_data
);

  logic [BUS_64-1:0] sh;

  // Each output lane picks the source byte addr_lo lanes above it; lanes
  // that would read past byte 7 are zero-filled.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [3:0] src;
    assign src = {1'b0, i_addr_lo} + 4'(gi);
    assign sh[gi*8 +: 8] = src[3] ? 8'h00 : i_rdata[{src[2:0], 3'b000} +: 8];
  end

  always_comb begin
    o_data = '0;
    case (i_ld_op)
      LD_LB:   o_data = {{56{sh[7]}}, sh[7:0]};
      LD_LH:   o_data = {{48{sh[15]}}, sh[15:0]};
      LD_LW:   o_data = {{32{sh[31]}}, sh[31:0]};
      LD_LD:   o_data = sh;
      LD_LBU:  o_data = {56'd0, sh[7:0]};
      LD_LHU:  o_data = {48'd0, sh[15:0]};
      LD_LWU:  o_data = {32'd0, sh[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_210544_wbu.sv
// Writeback stage: single-entry stage register with valid/ready handshake,
// register-file write port, difftest commit strobe and instret counter.
module ysyx_210544_wbu
  import ysyx_210544_wbu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_mem_valid,
  output logic                o_mem_ready,
  input  logic [BUS_64-1:0]   i_pc,
  input  logic [31:0]         i_inst,
  input  logic [BUS_RIDX-1:0] i_rd,
  input  logic                i_rd_wen,
  input  logic                i_wb_sel,
  input  logic [2:0]          i_ld_op,
  input  logic [2:0]          i_addr_lo,
  input  logic [BUS_64-1:0]   i_alu_data,
  input  logic [BUS_64-1:0]   i_mem_rdata,
  input  logic                i_wb_hold,
  output logic [BUS_RIDX-1:0] o_rd,
  output logic                o_rd_wen,
  output logic [BUS_64-1:0]   o_rd_data,
  output logic                o_commit_valid,
  output logic [BUS_64-1:0]   o_commit_pc,
  output logic [31:0]         o_commit_inst,
  output logic [BUS_64-1:0]   o_instret
);

  wb_entry_t         entry_reg;
  logic              valid_reg;
  logic [BUS_64-1:0] instret_reg;
  logic              retire;
  logic              accept;
  logic [BUS_64-1:0] ld_data;

  assign retire      = valid_reg && !i_wb_hold;
  assign o_mem_ready = !valid_reg || retire;
  assign accept      = i_mem_valid && o_mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg   <= 1'b0;
      entry_reg   <= '0;
      instret_reg <= '0;
    end else begin
      if (retire) begin
        instret_reg <= instret_reg + 64'd1;
      end
      // Accept takes priority so a same-edge retire/accept keeps valid high.
      if (accept) begin
        valid_reg           <= 1'b1;
        entry_reg.pc        <= i_pc;
        entry_reg.inst      <= i_inst;
        entry_reg.rd        <= i_rd;
        entry_reg.rd_wen    <= i_rd_wen;
        entry_reg.wb_sel    <= i_wb_sel;
        entry_reg.ld_op     <= i_ld_op;
        entry_reg.addr_lo   <= i_addr_lo;
        entry_reg.alu_data  <= i_alu_data;
        entry_reg.mem_rdata <= i_mem_rdata;
      end else if (retire) begin
        valid_reg <= 1'b0;
      end
    end
  end

  ysyx_210544_ld_ext u_ld_ext (
    .i_ld_op   (entry_reg.ld_op),
    .i_addr_lo (entry_reg.addr_lo),
    .i_rdata   (entry_reg.mem_rdata),
    .o_data    (ld_data)
  );

  assign o_rd           = entry_reg.rd;
  assign o_rd_wen       = retire && entry_reg.rd_wen && (entry_reg.rd != '0);
  assign o_rd_data      = (entry_reg.wb_sel == WB_SEL_MEM) ? ld_data : entry_reg.alu_data;
  assign o_commit_valid = retire;
  assign o_commit_pc    = entry_reg.pc;
  assign o_commit_inst  = entry_reg.inst;
  assign o_instret      = instret_reg;

endmodule

// File: tb/tb_ysyx_210544_wbu.sv
// Scoreboard bench for the writeback unit: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever a commit is presented.
module tb_ysyx_210544_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [63:0] i_pc;
  logic [31:0] i_inst;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic        i_wb_sel;
  logic [2:0]  i_ld_op;
  logic [2:0]  i_addr_lo;
  logic [63:0] i_alu_data;
  logic [63:0] i_mem_rdata;
  logic        i_wb_hold;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_data;
  logic        o_commit_valid;
  logic [63:0] o_commit_pc;
  logic [31:0] o_commit_inst;
  logic [63:0] o_instret;

  always #5 clk = ~clk;

  ysyx_210544_wbu dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_valid    (i_mem_valid),
    .o_mem_ready    (o_mem_ready),
    .i_pc           (i_pc),
    .i_inst         (i_inst),
    .i_rd           (i_rd),
    .i_rd_wen       (i_rd_wen),
    .i_wb_sel       (i_wb_sel),
    .i_ld_op        (i_ld_op),
    .i_addr_lo      (i_addr_lo),
    .i_alu_data     (i_alu_data),
    .i_mem_rdata    (i_mem_rdata),
    .i_wb_hold      (i_wb_hold),
    .o_rd           (o_rd),
    .o_rd_wen       (o_rd_wen),
    .o_rd_data      (o_rd_data),
    .o_commit_valid (o_commit_valid),
    .o_commit_pc    (o_commit_pc),
    .o_commit_inst  (o_commit_inst),
    .o_instret      (o_instret)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] rd_data;
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] mon_instret = '0;
  int          last_wait;

  localparam logic [63:0] RDATA = 64'h8070_6050_4030_2010;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: one line per retired instruction.
  always @(negedge clk) begin
    if (rst === 1'b1 && o_commit_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_commit", 64'(o_commit_pc), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("commit pc=0x%016h rd=%0d wen=%0b data=0x%016h instret=%0d",
                 o_commit_pc, o_rd, o_rd_wen, o_rd_data, o_instret);
        check("commit_pc", o_commit_pc, e.pc);
        check("commit_inst", 64'(o_commit_inst), 64'(e.inst));
        check("rd", 64'(o_rd), 64'(e.rd));
        check("rd_wen", 64'(o_rd_wen), 64'(e.rd_wen));
        if (e.rd_wen) check("rd_data", o_rd_data, e.rd_data);
        check("instret_at_commit", o_instret, mon_instret);
        mon_instret = mon_instret + 64'd1;
      end
    end
  end

  // Offer one entry; waits (bounded) for o_mem_ready and returns after the
  // accepting edge with i_mem_valid dropped.
  task automatic send(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                      input logic sel, input logic [2:0] op, input logic [2:0] off,
                      input logic [63:0] alu, input logic [63:0] exp_data, input bit push);
    bit   acc;
    exp_t e;
    i_mem_valid = 1'b1;
    i_pc        = pc;
    i_inst      = pc[31:0] ^ 32'h0000_0013;
    i_rd        = rd;
    i_rd_wen    = wen;
    i_wb_sel    = sel;
    i_ld_op     = op;
    i_addr_lo   = off;
    i_alu_data  = alu;
    i_mem_rdata = RDATA;
    e.rd = rd; e.rd_wen = wen && (rd != 5'd0); e.rd_data = exp_data;
    e.pc = pc; e.inst = i_inst;
    if (push) sb_q.push_back(e);
    last_wait = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = o_mem_ready;
      if (!acc) begin
        last_wait++;
        if (last_wait > 50) begin
          check("accept_timeout", 64'(last_wait), 64'd0);
          acc = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    i_mem_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b0; i_mem_valid = 1'b0; i_wb_hold = 1'b0;
    i_pc = '0; i_inst = '0; i_rd = '0; i_rd_wen = 1'b0; i_wb_sel = 1'b0;
    i_ld_op = '0; i_addr_lo = '0; i_alu_data = '0; i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(o_mem_ready), 64'd1);
    check("rst_rd_wen", 64'(o_rd_wen), 64'd0);
    check("rst_commit", 64'(o_commit_valid), 64'd0);
    check("rst_rd", 64'(o_rd), 64'd0);
    check("rst_rd_data", o_rd_data, 64'd0);
    check("rst_pc", o_commit_pc, 64'd0);
    check("rst_inst", 64'(o_commit_inst), 64'd0);
    check("rst_instret", o_instret, 64'd0);
    @(posedge clk); #1;

    // Back-to-back ALU ops
    send(64'h8000_0000, 5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'h11, 64'h11, 1'b1);
    check("b2b_wait0", 64'(last_wait), 64'd0);
    send(64'h8000_0004, 5'd6, 1'b1, 1'b0, 3'd0, 3'd0, 64'h22, 64'h22, 1'b1);
    check("b2b_wait1", 64'(last_wait), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    check("b2b_instret", o_instret, 64'd2);

    // Load extraction vectors
    send(64'h100, 5'd7,  1'b1, 1'b1, 3'b000, 3'd7, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    send(64'h104, 5'd8,  1'b1, 1'b1, 3'b100, 3'd7, 64'h0, 64'h80, 1'b1);
    send(64'h108, 5'd9,  1'b1, 1'b1, 3'b101, 3'd6, 64'h0, 64'h8070, 1'b1);
    send(64'h10c, 5'd10, 1'b1, 1'b1, 3'b010, 3'd4, 64'h0, 64'hFFFF_FFFF_8070_6050, 1'b1);
    send(64'h110, 5'd11, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0, RDATA, 1'b1);
    send(64'h114, 5'd12, 1'b1, 1'b1, 3'b001, 3'd0, 64'h0, 64'h2010, 1'b1);
    send(64'h118, 5'd13, 1'b1, 1'b1, 3'b110, 3'd4, 64'h0, 64'h8070_6050, 1'b1);
    send(64'h11c, 5'd14, 1'b1, 1'b1, 3'b000, 3'd1, 64'h0, 64'h20, 1'b1);
    send(64'h120, 5'd15, 1'b1, 1'b1, 3'b111, 3'd0, 64'h0, 64'h0, 1'b1);
    send(64'h124, 5'd16, 1'b1, 1'b1, 3'b010, 3'd6, 64'h0, 64'h8070, 1'b1);
    send(64'h128, 5'd17, 1'b1, 1'b1, 3'b011, 3'd4, 64'h0, 64'h8070_6050, 1'b1);
    send(64'h12c, 5'd18, 1'b1, 1'b0, 3'b011, 3'd0, 64'hCAFE, 64'hCAFE, 1'b1);

    // rd = 0 commits without writing
    send(64'h200, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'h55, 64'h55, 1'b1);
    // store-like: no rd write
    send(64'h204, 5'd3, 1'b0, 1'b0, 3'd0, 3'd0, 64'h66, 64'h66, 1'b1);
    @(negedge clk);

    // Hold with an entry pending
    @(posedge clk); #1;
    i_wb_hold = 1'b1;
    @(negedge clk);
    check("hold_empty_ready", 64'(o_mem_ready), 64'd1);
    @(posedge clk); #1;
    send(64'h300, 5'd20, 1'b1, 1'b0, 3'd0, 3'd0, 64'h77, 64'h77, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_ready", 64'(o_mem_ready), 64'd0);
      check("hold_commit", 64'(o_commit_valid), 64'd0);
      check("hold_rd_wen", 64'(o_rd_wen), 64'd0);
      check("hold_rd_data", o_rd_data, 64'h77);
      check("hold_pc", o_commit_pc, 64'h300);
    end
    @(posedge clk); #1;
    i_wb_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_single_commit", 64'(o_commit_valid), 64'd0);
    check("hold_single_write", 64'(o_rd_wen), 64'd0);

    // Reset while an entry is held
    @(posedge clk); #1;
    i_wb_hold = 1'b1;
    send(64'h400, 5'd21, 1'b1, 1'b0, 3'd0, 3'd0, 64'h88, 64'h88, 1'b0);
    rst = 1'b0;
    i_mem_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    i_mem_valid = 1'b0;
    mon_instret = '0;
    @(negedge clk);
    check("rstmid_commit", 64'(o_commit_valid), 64'd0);
    check("rstmid_rd_wen", 64'(o_rd_wen), 64'd0);
    check("rstmid_instret", o_instret, 64'd0);
    check("rstmid_ready", 64'(o_mem_ready), 64'd1);
    @(posedge clk); #1;
    i_wb_hold = 1'b0;

    // instret wrap
    force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_reg;
    mon_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    send(64'h500, 5'd22, 1'b1, 1'b0, 3'd0, 3'd0, 64'h99, 64'h99, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    check("instret_wrap", o_instret, 64'd0);

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
